uart_frame_loader: RTL and testbench
====================================

Name: uart_frame_loader

Overview:
Byte-stream frame assembler between the uart_rx byte output and the image memory / classifier. It receives one label byte, then IMG_W*IMG_H pixels of BYTES_PER_PIX little-endian bytes each. Each assembled pixel is written to a row-major memory port. When the classifier returns a result, the block sends it back as one ASCII character over the uart_tx handshake. Additions over the fixed 28x28x32 loader: parameterised geometry, a clean per-pixel accumulator, inter-byte timeout resync, error and done reporting, and a result reply.

Parameters:
IMG_W, 28, pixels per row (x extent)
IMG_H, 28, rows (y extent)
BYTES_PER_PIX, 4, bytes per pixel, 1..4; PIX_W = 8*BYTES_PER_PIX
ADDR_W, 10, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
TIMEOUT_CYCLES, 100000, max sys_clk cycles allowed between bytes inside a frame

Ports:
sys_clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_ready  in  1  one-cycle pulse from uart_rx: in_data valid
in_data  in  8  received byte
wr_en  out  1  one-cycle pixel write strobe
wr_addr  out  ADDR_W  y*IMG_W + x
wr_data  out  PIX_W  assembled pixel
label  out  8  captured label byte
label_valid  out  1  label held for current frame
frame_done  out  1  one-cycle pulse with final pixel write
frame_err  out  1  one-cycle pulse on timeout abort
busy  out  1  state != WAIT_LABEL
result_valid  in  1  one-cycle pulse from classifier
result  in  4  class index
tx_ready  in  1  uart_tx idle (out_ready)
tx_start  out  1  one-cycle start pulse to uart_tx
tx_data  out  8  byte to transmit, held stable after tx_start

Behaviour:
- Reset (sync, rst=1 at edge): state=WAIT_LABEL. x, y, byte_idx, accumulator, timeout counter = 0. wr_en, frame_done, frame_err, tx_start, label_valid = 0. label = 0, tx_data = 0, wr_addr = 0, wr_data = 0. Reset mid-frame discards the partial frame with no write.
- States: WAIT_LABEL -> RX_PIX -> WAIT_RESULT -> SEND -> WAIT_LABEL.
- WAIT_LABEL: on in_ready, label<=in_data, label_valid<=1, go RX_PIX. No timeout in this state.
- RX_PIX: each in_ready places in_data in accumulator bits [8*byte_idx+7 : 8*byte_idx]. Byte 0 clears the other accumulator bits, so stale data never ORs in.
- On the byte with byte_idx == BYTES_PER_PIX-1: next cycle wr_en=1, wr_data=assembled pixel, wr_addr=y*IMG_W+x (latency 1 cycle from the last in_ready). Then byte_idx=0 and x increments; at x == IMG_W-1, x wraps to 0 and y increments.
- Final pixel (x=IMG_W-1, y=IMG_H-1): frame_done pulses in the same cycle as its wr_en; x and y return to 0; go WAIT_RESULT.
- Timeout: the counter clears on every in_ready and increments each cycle in RX_PIX. When it reaches TIMEOUT_CYCLES-1 with no byte: frame_err pulses for 1 cycle, label_valid=0, x/y/byte_idx=0, go WAIT_LABEL. No wr_en is issued.
- If in_ready and timeout expiry coincide, the byte is accepted and the counter clears.
- WAIT_RESULT: in_ready is ignored (dropped). On result_valid, tx_data <= (result<=9) ? 8'h30+result : 8'h3F ('?'). Go SEND.
- SEND: tx_start=1 for exactly one cycle in the first cycle tx_ready=1, then go WAIT_LABEL with label_valid=0. tx_data stays held until the next result. While tx_ready=0, wait indefinitely. in_ready is ignored.
- result_valid outside WAIT_RESULT is ignored.
- busy is combinational from state. All other outputs are registered.

Test Plan:
- Params IMG_W=2, IMG_H=2, BYTES_PER_PIX=2; bytes 05,11,22,33,44,55,66,77,88 -> label=05; writes (0,2211),(1,4433),(2,6655),(3,8877), one cycle after each pixel's last byte; frame_done coincident with the addr 3 write.
- Two back-to-back frames with different data -> the second frame's wr_data has no bits carried over from the first (accumulator cleared).
- Label + 3 bytes, then silence for TIMEOUT_CYCLES -> frame_err pulses once, busy drops, no write for the partial pixel; a following full frame loads from addr 0.
- Byte arriving exactly at the expiry cycle -> accepted, no frame_err.
- After frame_done, result_valid with result=7 while tx_ready=0 for 20 cycles -> tx_start is a single pulse on the first tx_ready=1 cycle, tx_data=8'h37; with result=12 -> tx_data=8'h3F.
- rst asserted mid-RX_PIX -> next edge all outputs 0 and state WAIT_LABEL; the next byte is taken as the label.

Source files
------------

// File: rtl/uart_frame_loader.sv
// Assembles label + multi-byte pixel stream from uart_rx into row-major memory writes,
// with inter-byte timeout resync and a one-character ASCII reply of the classifier result.
module uart_frame_loader #(
    parameter int unsigned IMG_W          = 28,
    parameter int unsigned IMG_H          = 28,
    parameter int unsigned BYTES_PER_PIX  = 4,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         in_ready,
    input  logic [7:0]                   in_data,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [8*BYTES_PER_PIX-1:0]   wr_data,
    output logic [7:0]                   label,
    output logic                         label_valid,
    output logic                         frame_done,
    output logic                         frame_err,
    output logic                         busy,
    input  logic                         result_valid,
    input  logic [3:0]                   result,
    input  logic                         tx_ready,
    output logic                         tx_start,
    output logic [7:0]                   tx_data
);

    localparam int unsigned PIX_W = 8 * BYTES_PER_PIX;
    localparam int unsigned X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned BI_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam int unsigned SH_W  = BI_W + 3;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_LABEL,
        RX_PIX,
        WAIT_RESULT,
        SEND
    } state_t;

    state_t             state;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [ADDR_W-1:0]  addr;
    logic [BI_W-1:0]    byte_idx;
    logic [PIX_W-1:0]   acc;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [SH_W-1:0]    shift;
    logic [PIX_W-1:0]   acc_next;
    logic [7:0]         result_char;
    logic               last_byte;
    logic               last_col;
    logic               last_row;

    assign busy = (state != WAIT_LABEL);

    // Byte 0 starts a fresh pixel so nothing from the previous pixel survives.
    always_comb begin
        shift    = {byte_idx, 3'b000};
        acc_next = (byte_idx == '0) ? '0 : acc;
        acc_next = (acc_next & ~(PIX_W'(8'hFF) << shift)) | (PIX_W'(in_data) << shift);
    end

    always_comb begin
        result_char = (result <= 4'd9) ? (8'h30 + {4'b0000, result}) : 8'h3F;
        last_byte   = (byte_idx == BI_W'(BYTES_PER_PIX - 1));
        last_col    = (x == X_W'(IMG_W - 1));
        last_row    = (y == Y_W'(IMG_H - 1));
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= WAIT_LABEL;
            x           <= '0;
            y           <= '0;
            addr        <= '0;
            byte_idx    <= '0;
            acc         <= '0;
            tmo_cnt     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            label       <= '0;
            label_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            tx_start   <= 1'b0;

            case (state)
                WAIT_LABEL: begin
                    if (in_ready) begin
                        label       <= in_data;
                        label_valid <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= RX_PIX;
                    end
                end

                RX_PIX: begin
                    // A byte landing on the expiry cycle wins over the timeout.
                    if (in_ready) begin
                        tmo_cnt <= '0;
                        acc     <= acc_next;
                        if (last_byte) begin
                            byte_idx <= '0;
                            wr_en    <= 1'b1;
                            wr_data  <= acc_next;
                            wr_addr  <= addr;
                            if (last_col) begin
                                x <= '0;
                                if (last_row) begin
                                    y          <= '0;
                                    addr       <= '0;
                                    frame_done <= 1'b1;
                                    state      <= WAIT_RESULT;
                                end else begin
                                    y    <= y + Y_W'(1);
                                    addr <= addr + ADDR_W'(1);
                                end
                            end else begin
                                x    <= x + X_W'(1);
                                addr <= addr + ADDR_W'(1);
                            end
                        end else begin
                            byte_idx <= byte_idx + BI_W'(1);
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        frame_err   <= 1'b1;
                        label_valid <= 1'b0;
                        x           <= '0;
                        y           <= '0;
                        addr        <= '0;
                        byte_idx    <= '0;
                        tmo_cnt     <= '0;
                        state       <= WAIT_LABEL;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                WAIT_RESULT: begin
                    if (result_valid) begin
                        tx_data <= result_char;
                        state   <= SEND;
                    end
                end

                SEND: begin
                    if (tx_ready) begin
                        tx_start    <= 1'b1;
                        label_valid <= 1'b0;
                        state       <= WAIT_LABEL;
                    end
                end

                default: state <= WAIT_LABEL;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader on a 2x2 image of 2-byte pixels with a short timeout.
module tb_uart_frame_loader;

    localparam int unsigned T    = 40;
    localparam int unsigned NPIX = 4;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  label;
    logic        label_valid;
    logic        frame_done;
    logic        frame_err;
    logic        busy;
    logic        result_valid;
    logic [3:0]  result;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_data;

    uart_frame_loader #(
        .IMG_W(2), .IMG_H(2), .BYTES_PER_PIX(2), .ADDR_W(2), .TIMEOUT_CYCLES(T)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .label(label), .label_valid(label_valid), .frame_done(frame_done),
        .frame_err(frame_err), .busy(busy), .result_valid(result_valid),
        .result(result), .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] done;
        logic [31:0] cyc;
    } wr_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] cyc;
    } tx_exp_t;

    wr_exp_t wq[$];
    tx_exp_t txq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_cnt = 0;
    int tx_cnt  = 0;
    int tx_exp  = 0;
    logic [31:0] exp_err_cyc = 32'hFFFF_FFFF;
    logic [7:0]  fb [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Output monitor: pops expected writes / replies as the DUT produces them.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wr", 32'(wr_en), 32'd0);
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    chk("wr_addr", 32'(wr_addr), e.addr);
                    chk("wr_data", 32'(wr_data), e.data);
                    chk("wr_cyc", 32'(cyc), e.cyc);
                    chk("frame_done", 32'(frame_done), e.done);
                end
            end else if (frame_done) begin
                chk("done_alone", 32'(frame_done), 32'd0);
            end
            if (frame_err) begin
                err_cnt++;
                chk("err_cyc", 32'(cyc), exp_err_cyc);
            end
            if (tx_start) begin
                tx_cnt++;
                if (txq.size() == 0) begin
                    chk("unexpected_tx", 32'(tx_start), 32'd0);
                end else begin
                    tx_exp_t t;
                    t = txq.pop_front();
                    chk("tx_data_at_start", 32'(tx_data), t.data);
                    chk("tx_cyc", 32'(cyc), t.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_ready = 1'b1;
        in_data  = b;
        tick();
        in_ready = 1'b0;
    endtask

    task automatic send_pixel(input int a, input logic [7:0] b0, input logic [7:0] b1, input bit done);
        wr_exp_t e;
        send_byte(b0);
        e.addr = 32'(a);
        e.data = {16'h0000, b1, b0};
        e.done = {31'd0, done};
        e.cyc  = 32'(cyc + 1);
        wq.push_back(e);
        send_byte(b1);
    endtask

    task automatic send_pixels();
        for (int p = 0; p < NPIX; p++)
            send_pixel(p, fb[2*p], fb[2*p+1], p == NPIX - 1);
    endtask

    task automatic do_result(input logic [3:0] r, input logic [7:0] ch, input int hold);
        tx_exp_t t;
        result       = r;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        chk("tx_data_latched", 32'(tx_data), 32'(ch));
        chk("busy_in_send", 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) tick();
        t.data = 32'(ch);
        t.cyc  = 32'(cyc + 1);
        txq.push_back(t);
        tx_exp++;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
        tick();
        chk("busy_idle", 32'(busy), 32'd0);
        chk("label_valid_clr", 32'(label_valid), 32'd0);
        chk("tx_data_held", 32'(tx_data), 32'(ch));
    endtask

    initial begin
        rst = 1'b1; in_ready = 1'b0; in_data = '0;
        result_valid = 1'b0; result = '0; tx_ready = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        rst = 1'b0;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_label", 32'(label), 32'd0);
        chk("rst_label_valid", 32'(label_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);

        // Frame 1: reference stream, then a dropped byte and a delayed reply.
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_byte(8'h05);
        chk("label_early_busy", 32'(busy), 32'd1);
        send_pixels();
        chk("label", 32'(label), 32'h05);
        chk("label_valid", 32'(label_valid), 32'd1);
        chk("busy_wait_result", 32'(busy), 32'd1);
        send_byte(8'h99);
        chk("label_kept", 32'(label), 32'h05);
        do_result(4'd7, 8'h37, 20);

        // result_valid while idle must be ignored.
        tx_ready = 1'b1; result = 4'd3; result_valid = 1'b1;
        tick();
        result_valid = 1'b0; tx_ready = 1'b0;
        tick();
        chk("stray_result_tx_data", 32'(tx_data), 32'h37);
        chk("stray_result_busy", 32'(busy), 32'd0);

        // Frames 2 and 3: all-ones then small values, so stale bits would show.
        fb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_byte(8'hA0);
        send_pixels();
        do_result(4'd12, 8'h3F, 0);
        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_byte(8'hA1);
        send_pixels();
        chk("label_f3", 32'(label), 32'hA1);
        do_result(4'd0, 8'h30, 3);

        // Timeout: one full pixel, one partial byte, then silence.
        send_byte(8'hA2);
        send_pixel(0, 8'hC1, 8'hC2, 1'b0);
        exp_err_cyc = 32'(cyc + 1 + T);
        send_byte(8'h5A);
        for (int i = 0; i < T + 3; i++) tick();
        chk("err_count_timeout", 32'(err_cnt), 32'd1);
        chk("busy_after_err", 32'(busy), 32'd0);
        chk("label_valid_after_err", 32'(label_valid), 32'd0);
        exp_err_cyc = 32'hFFFF_FFFF;

        fb = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        send_byte(8'hA3);
        send_pixels();
        do_result(4'd9, 8'h39, 1);

        // Byte landing exactly on the expiry cycle is accepted.
        send_byte(8'hA4);
        send_pixel(0, 8'h0D, 8'h0E, 1'b0);
        for (int i = 0; i < T - 1; i++) tick();
        send_pixel(1, 8'hE1, 8'hE2, 1'b0);
        send_pixel(2, 8'hE3, 8'hE4, 1'b0);
        send_pixel(3, 8'hE5, 8'hE6, 1'b1);
        chk("err_count_edge", 32'(err_cnt), 32'd1);
        do_result(4'd2, 8'h32, 0);

        // Reset mid-frame: partial pixel dropped, next byte is a label.
        send_byte(8'hA5);
        send_pixel(0, 8'h31, 8'h32, 1'b0);
        send_byte(8'h33);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_wr_en", 32'(wr_en), 32'd0);
        chk("mrst_wr_addr", 32'(wr_addr), 32'd0);
        chk("mrst_wr_data", 32'(wr_data), 32'd0);
        chk("mrst_label", 32'(label), 32'd0);
        chk("mrst_label_valid", 32'(label_valid), 32'd0);
        chk("mrst_tx_data", 32'(tx_data), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        send_byte(8'h42);
        chk("label_after_rst", 32'(label), 32'h42);
        chk("label_valid_after_rst", 32'(label_valid), 32'd1);
        fb = '{8'h9A, 8'h9B, 8'h9C, 8'h9D, 8'h9E, 8'h9F, 8'hA6, 8'hA7};
        send_pixels();
        do_result(4'd5, 8'h35, 0);

        repeat (5) tick();
        chk("wr_queue_drained", 32'(wq.size()), 32'd0);
        chk("tx_queue_drained", 32'(txq.size()), 32'd0);
        chk("err_total", 32'(err_cnt), 32'd1);
        chk("tx_total", 32'(tx_cnt), 32'(tx_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
